// File: rtl/lut_interp.sv
// Sequencer that reads two adjacent coefficient-table entries and linearly
// interpolates between them, returning the result on a valid/ready port.
module lut_interp #(
   parameter int SEL_W  = 5,
   parameter int VAL_W  = 47,
   parameter int FRAC_W = 11
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SEL_W+FRAC_W-1:0] in_x,
   output logic [SEL_W-1:0]        lut_sel,
   input  logic [VAL_W-1:0]        lut_val,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [VAL_W-1:0]        out_y
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD0  = 3'd1,
      RD1  = 3'd2,
      CALC = 3'd3,
      OUT  = 3'd4
   } state_t;

   localparam logic [SEL_W-1:0] TOP_IDX = {SEL_W{1'b1}};
   localparam int               PROD_W  = VAL_W + FRAC_W + 1;

   state_t             state_r;
   logic [SEL_W-1:0]   idx_r;
   logic [FRAC_W-1:0]  frac_r;
   logic [VAL_W-1:0]   base_r;
   logic [VAL_W-1:0]   upper_r;

   // base + floor(signed(upper-base) * frac / 2**FRAC_W), wrapped to VAL_W.
   // Only the low PROD_W bits of the product are needed, and the true product
   // always fits there, so an unsigned multiply of sign-extended operands works.
   function automatic logic [VAL_W-1:0] interp(
      input logic [VAL_W-1:0]  b,
      input logic [VAL_W-1:0]  u,
      input logic [FRAC_W-1:0] f
   );
      logic [VAL_W:0]    delta;
      logic [PROD_W-1:0] delta_ext;
      logic [PROD_W-1:0] frac_ext;
      logic [PROD_W-1:0] prod;
      delta     = {1'b0, u} - {1'b0, b};
      delta_ext = {{FRAC_W{delta[VAL_W]}}, delta};
      frac_ext  = {{(VAL_W + 1){1'b0}}, f};
      prod      = delta_ext * frac_ext;
      return b + prod[VAL_W+FRAC_W-1:FRAC_W];
   endfunction

   // Transaction sequencer: accept, read base, read upper, compute, hand off.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= IDLE;
         idx_r     <= {SEL_W{1'b0}};
         frac_r    <= {FRAC_W{1'b0}};
         base_r    <= {VAL_W{1'b0}};
         upper_r   <= {VAL_W{1'b0}};
         lut_sel   <= {SEL_W{1'b0}};
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_y     <= {VAL_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready) begin
                  idx_r    <= in_x[SEL_W+FRAC_W-1 -: SEL_W];
                  frac_r   <= in_x[FRAC_W-1:0];
                  lut_sel  <= in_x[SEL_W+FRAC_W-1 -: SEL_W];
                  in_ready <= 1'b0;
                  state_r  <= RD0;
               end
            end
            RD0: begin
               base_r  <= lut_val;
               // The top entry pairs with itself rather than wrapping to 0.
               lut_sel <= (idx_r == TOP_IDX) ? idx_r : idx_r + {{(SEL_W-1){1'b0}}, 1'b1};
               state_r <= RD1;
            end
            RD1: begin
               upper_r <= lut_val;
               state_r <= CALC;
            end
            CALC: begin
               out_y     <= interp(base_r, upper_r, frac_r);
               out_valid <= 1'b1;
               state_r   <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_r   <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule
